// File: rtl/vit_pkg.sv
// Shared Viterbi constants, trellis helpers and the branch-metric pair type.
// Trellis: state s with input bit u moves to {u, s[5:1]}, so both predecessors
// of state j share the low five bits of j and the branch bit j[5].
package vit_pkg;

  localparam int NUM_STATES = 64;
  localparam int STATE_W    = 6;
  localparam int BM_W       = 2;
  localparam int BMP_W      = 2 * BM_W;

  // One state's pair of branch metrics; path1 sits in the upper bits of the nibble.
  typedef struct packed {
    logic [BM_W-1:0] path1;
    logic [BM_W-1:0] path0;
  } bm_pair_t;

  // Even predecessor of state j.
  function automatic logic [STATE_W-1:0] pred0(input logic [STATE_W-1:0] j);
    return {j[STATE_W-2:0], 1'b0};
  endfunction

  // Odd predecessor of state j.
  function automatic logic [STATE_W-1:0] pred1(input logic [STATE_W-1:0] j);
    return {j[STATE_W-2:0], 1'b1};
  endfunction

  // Input bit on both branches entering state j.
  function automatic logic ubit(input logic [STATE_W-1:0] j);
    return j[STATE_W-1];
  endfunction

endpackage

// File: rtl/acs_unit.sv
// Single add-compare-select cell: two saturating candidate sums, select the
// smaller (ties go to the even predecessor), then apply normalisation.
module acs_unit
  import vit_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [BM_W-1:0] i_bm0,
  input  logic [BM_W-1:0] i_bm1,
  input  logic            i_norm,
  output logic [PM_W-1:0] o_pm,
  output logic            o_dec,
  output logic            o_sat
);

  logic [PM_W:0]   w_sum0;
  logic [PM_W:0]   w_sum1;
  logic [PM_W-1:0] w_c0;
  logic [PM_W-1:0] w_c1;
  logic [PM_W-1:0] w_sel;

  // When norm is set every source has its MSB set, so each selected metric is at
  // least half scale and subtracting half scale is just clearing the MSB.
  always_comb begin
    w_sum0 = {1'b0, i_pm0} + {{(PM_W + 1 - BM_W){1'b0}}, i_bm0};
    w_sum1 = {1'b0, i_pm1} + {{(PM_W + 1 - BM_W){1'b0}}, i_bm1};
    w_c0   = w_sum0[PM_W] ? {PM_W{1'b1}} : w_sum0[PM_W-1:0];
    w_c1   = w_sum1[PM_W] ? {PM_W{1'b1}} : w_sum1[PM_W-1:0];
    o_dec  = (w_c1 < w_c0);
    w_sel  = o_dec ? w_c1 : w_c0;
    o_pm   = {w_sel[PM_W-1] & ~i_norm, w_sel[PM_W-2:0]};
    o_sat  = w_sum0[PM_W] | w_sum1[PM_W];
  end

endmodule

// File: rtl/acs_pm_bank.sv
// 64-state ACS stage and path-metric bank for the K=7 rate-1/2 Viterbi decoder.
// One symbol per in_valid cycle; decisions and best state are registered one
// cycle later. Optional feature macro: ACS_BEST_STATE_EN builds the 64-way
// minimum tree; without it best_state is tied to 0.
module acs_pm_bank
  import vit_pkg::*;
#(
  parameter int PM_W     = 8,
  parameter int INIT_PEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        frame_start,
  input  logic [NUM_STATES*BMP_W-1:0] bm_flat,
  output logic                        dec_valid,
  output logic [NUM_STATES-1:0]       dec,
  output logic [STATE_W-1:0]          best_state,
  output logic                        pm_ovf
);

  logic [PM_W-1:0]       r_pm     [NUM_STATES];
  logic                  r_decValid;
  logic [NUM_STATES-1:0] r_dec;
  logic                  r_ovf;

  logic [PM_W-1:0]       w_srcPm  [NUM_STATES];
  logic [PM_W-1:0]       w_newPm  [NUM_STATES];
  logic [NUM_STATES-1:0] w_dec;
  logic [NUM_STATES-1:0] w_sat;
  logic                  w_norm;
  logic                  w_restart;

  assign w_restart = in_valid & frame_start;

  // Pick the source metrics (init vector on a frame start) and derive norm from them.
  always_comb begin
    w_norm = 1'b1;
    for (int s = 0; s < NUM_STATES; s++) begin
      if (w_restart) begin
        w_srcPm[s] = (s == 0) ? '0 : PM_W'(INIT_PEN);
      end else begin
        w_srcPm[s] = r_pm[s];
      end
      w_norm = w_norm & w_srcPm[s][PM_W-1];
    end
  end

  for (genvar j = 0; j < NUM_STATES; j++) begin : g_acs
    localparam int P0 = int'(pred0(STATE_W'(j)));
    localparam int P1 = int'(pred1(STATE_W'(j)));
    localparam bit U  = ubit(STATE_W'(j));

    bm_pair_t w_pair0;
    bm_pair_t w_pair1;

    assign w_pair0 = bm_flat[BMP_W*P0 +: BMP_W];
    assign w_pair1 = bm_flat[BMP_W*P1 +: BMP_W];

    acs_unit #(.PM_W(PM_W)) u_acs (
      .i_pm0  (w_srcPm[P0]),
      .i_pm1  (w_srcPm[P1]),
      .i_bm0  (U ? w_pair0.path1 : w_pair0.path0),
      .i_bm1  (U ? w_pair1.path1 : w_pair1.path0),
      .i_norm (w_norm),
      .o_pm   (w_newPm[j]),
      .o_dec  (w_dec[j]),
      .o_sat  (w_sat[j])
    );
  end

  // Metric bank and decision outputs: update on each accepted symbol, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : PM_W'(INIT_PEN);
      end
      r_decValid <= 1'b0;
      r_dec      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_decValid <= in_valid;
      if (in_valid) begin
        for (int s = 0; s < NUM_STATES; s++) begin
          r_pm[s] <= w_newPm[s];
        end
        r_dec <= w_dec;
        r_ovf <= r_ovf | (|w_sat);
      end
    end
  end

  assign dec_valid = r_decValid;
  assign dec       = r_dec;
  assign pm_ovf    = r_ovf;

`ifdef ACS_BEST_STATE_EN
  logic [PM_W-1:0]    w_v32 [32];
  logic [STATE_W-1:0] w_i32 [32];
  logic [PM_W-1:0]    w_v16 [16];
  logic [STATE_W-1:0] w_i16 [16];
  logic [PM_W-1:0]    w_v8  [8];
  logic [STATE_W-1:0] w_i8  [8];
  logic [PM_W-1:0]    w_v4  [4];
  logic [STATE_W-1:0] w_i4  [4];
  logic [PM_W-1:0]    w_v2  [2];
  logic [STATE_W-1:0] w_i2  [2];
  logic [STATE_W-1:0] w_minIdx;
  logic [STATE_W-1:0] r_best;

  // Binary minimum tree; the right operand only wins when strictly smaller, so ties keep the lower index.
  always_comb begin
    for (int n = 0; n < 32; n++) begin
      if (w_newPm[2*n+1] < w_newPm[2*n]) begin
        w_v32[n] = w_newPm[2*n+1];
        w_i32[n] = STATE_W'(2*n+1);
      end else begin
        w_v32[n] = w_newPm[2*n];
        w_i32[n] = STATE_W'(2*n);
      end
    end
    for (int n = 0; n < 16; n++) begin
      w_v16[n] = (w_v32[2*n+1] < w_v32[2*n]) ? w_v32[2*n+1] : w_v32[2*n];
      w_i16[n] = (w_v32[2*n+1] < w_v32[2*n]) ? w_i32[2*n+1] : w_i32[2*n];
    end
    for (int n = 0; n < 8; n++) begin
      w_v8[n] = (w_v16[2*n+1] < w_v16[2*n]) ? w_v16[2*n+1] : w_v16[2*n];
      w_i8[n] = (w_v16[2*n+1] < w_v16[2*n]) ? w_i16[2*n+1] : w_i16[2*n];
    end
    for (int n = 0; n < 4; n++) begin
      w_v4[n] = (w_v8[2*n+1] < w_v8[2*n]) ? w_v8[2*n+1] : w_v8[2*n];
      w_i4[n] = (w_v8[2*n+1] < w_v8[2*n]) ? w_i8[2*n+1] : w_i8[2*n];
    end
    for (int n = 0; n < 2; n++) begin
      w_v2[n] = (w_v4[2*n+1] < w_v4[2*n]) ? w_v4[2*n+1] : w_v4[2*n];
      w_i2[n] = (w_v4[2*n+1] < w_v4[2*n]) ? w_i4[2*n+1] : w_i4[2*n];
    end
    w_minIdx = (w_v2[1] < w_v2[0]) ? w_i2[1] : w_i2[0];
  end

  // Best-state register follows the same accept/hold rule as the decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best <= '0;
    end else if (in_valid) begin
      r_best <= w_minIdx;
    end
  end

  assign best_state = r_best;
`else
  assign best_state = '0;
`endif

endmodule

// File: tb/tb_acs_pm_bank.sv
// Self-checking bench for acs_pm_bank: hand-computed vector table, then
// multi-cycle sequences checked against a behavioural trellis model.
module tb_acs_pm_bank;
  localparam int PM_W     = 8;
  localparam int INIT_PEN = 16;
  localparam int NS       = 64;
  localparam int MAXPM    = (1 << PM_W) - 1;
  localparam int HALF     = 1 << (PM_W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic [255:0] bm_flat = '0;
  logic         dec_valid;
  logic [63:0]  dec;
  logic [5:0]   best_state;
  logic         pm_ovf;

  acs_pm_bank #(.PM_W(PM_W), .INIT_PEN(INIT_PEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .bm_flat     (bm_flat),
    .dec_valid   (dec_valid),
    .dec         (dec),
    .best_state  (best_state),
    .pm_ovf      (pm_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] bm;
    logic [63:0]  expDec;
    logic [5:0]   expBest;
  } vec_t;

  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  int          mPm[NS];
  bit          mOvf;
  int          normCount = 0;
  bit          pending;
  logic [63:0] pDec;
  logic [5:0]  pBest;
  logic        pOvf;
  logic [63:0] lastDec;
  logic [5:0]  lastBest;
  logic [63:0] sDec;
  logic [255:0] zbm;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NS; s++) mPm[s] = (s == 0) ? 0 : INIT_PEN;
    mOvf     = 1'b0;
    pending  = 1'b0;
    lastDec  = '0;
    lastBest = '0;
  endtask

  // Straight from the trellis description: predecessors 2j mod 64 and +1, branch bit j[5].
  task automatic modelStep(input bit fs, input logic [255:0] bm);
    int src[NS];
    int nPm[NS];
    bit norm;
    int p0, p1, u, c0, c1, best;
    logic [63:0] d;
    norm = 1'b1;
    for (int s = 0; s < NS; s++) begin
      src[s] = fs ? ((s == 0) ? 0 : INIT_PEN) : mPm[s];
      if (src[s] < HALF) norm = 1'b0;
    end
    if (norm) normCount++;
    d = '0;
    for (int j = 0; j < NS; j++) begin
      p0 = (2 * j) % NS;
      p1 = p0 + 1;
      u  = j / 32;
      c0 = src[p0] + int'(bm[4*p0 + 2*u +: 2]);
      c1 = src[p1] + int'(bm[4*p1 + 2*u +: 2]);
      if (c0 > MAXPM) begin c0 = MAXPM; mOvf = 1'b1; end
      if (c1 > MAXPM) begin c1 = MAXPM; mOvf = 1'b1; end
      if (c1 < c0) begin nPm[j] = c1; d[j] = 1'b1; end
      else nPm[j] = c0;
      if (norm) nPm[j] = nPm[j] - HALF;
    end
    best = 0;
    for (int j = 1; j < NS; j++) if (nPm[j] < nPm[best]) best = j;
    for (int j = 0; j < NS; j++) mPm[j] = nPm[j];
    pDec = d;
`ifdef ACS_BEST_STATE_EN
    pBest = 6'(best);
`else
    pBest = 6'd0;
`endif
    pOvf    = mOvf;
    pending = 1'b1;
  endtask

  // Called on a falling edge: checks the beat for the last driven symbol, or the hold behaviour.
  task automatic checkOutput();
    sDec = dec;
    if (pending) begin
      checkVal("dec_valid_beat", {63'd0, dec_valid}, 64'd1);
      checkVal("dec", dec, pDec);
      checkVal("best_state", {58'd0, best_state}, {58'd0, pBest});
      checkVal("pm_ovf", {63'd0, pm_ovf}, {63'd0, pOvf});
      lastDec  = pDec;
      lastBest = pBest;
      pending  = 1'b0;
    end else begin
      checkVal("dec_valid_idle", {63'd0, dec_valid}, 64'd0);
      checkVal("dec_hold", dec, lastDec);
      checkVal("best_hold", {58'd0, best_state}, {58'd0, lastBest});
    end
  endtask

  task automatic applyStimulus(input bit fs, input logic [255:0] bm);
    @(negedge clk);
    checkOutput();
    in_valid    = 1'b1;
    frame_start = fs;
    bm_flat     = bm;
    modelStep(fs, bm);
  endtask

  // frame_start and bm are deliberately garbage here: they must be ignored without in_valid.
  task automatic idleCycle();
    @(negedge clk);
    checkOutput();
    in_valid    = 1'b0;
    frame_start = 1'b1;
    bm_flat     = {8{$urandom()}};
  endtask

  function automatic logic [255:0] makeBm(input int e0, input int e1, input int o0, input int o1);
    logic [255:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) begin
      if (s % 2 == 1) v[4*s +: 4] = {2'(o1), 2'(o0)};
      else            v[4*s +: 4] = {2'(e1), 2'(e0)};
    end
    return v;
  endfunction

  function automatic logic [255:0] randBm();
    logic [255:0] v;
    for (int f = 0; f < 128; f++) v[2*f +: 2] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  // Hamming weight of the 171/133 encoder output: distance to a received 00 pair.
  function automatic logic [255:0] zeroStreamBm();
    logic [255:0] v;
    logic [6:0]   r;
    int           w;
    for (int s = 0; s < NS; s++) begin
      for (int u = 0; u < 2; u++) begin
        r = {u[0], 6'(s)};
        w = int'(^(r & 7'o171)) + int'(^(r & 7'o133));
        v[4*s + 2*u +: 2] = 2'(w);
      end
    end
    return v;
  endfunction

  initial begin
    logic [255:0] seedBm;

    vecs[0] = '{makeBm(0, 0, 0, 0), 64'h0000_0000_0000_0000, 6'd0};
    vecs[1] = '{makeBm(2, 2, 0, 0), 64'hFFFF_FFFE_FFFF_FFFE, 6'd0};
    vecs[2] = '{makeBm(0, 2, 2, 0), 64'hFFFF_FFFE_0000_0000, 6'd0};
    vecs[3] = '{makeBm(2, 2, 2, 2), 64'h0000_0000_0000_0000, 6'd0};
    vecs[4] = '{makeBm(2, 0, 0, 2), 64'h0000_0000_FFFF_FFFE, 6'd32};

    modelReset();
    #3;
    checkVal("reset_dec_valid", {63'd0, dec_valid}, 64'd0);
    checkVal("reset_dec", dec, 64'd0);
    checkVal("reset_best", {58'd0, best_state}, 64'd0);
    checkVal("reset_ovf", {63'd0, pm_ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].bm);
      pDec = vecs[i].expDec;
`ifdef ACS_BEST_STATE_EN
      pBest = vecs[i].expBest;
`else
      pBest = 6'd0;
`endif
      idleCycle();
    end
    idleCycle();

    seedBm = '0;
    seedBm[3:0] = 4'b1010;
    applyStimulus(1'b1, seedBm);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, seedBm);
    idleCycle();
    checkVal("seed_odd_dec0", {63'd0, sDec[0]}, 64'd1);

    zbm = zeroStreamBm();
    applyStimulus(1'b1, zbm);
    for (int i = 0; i < 19; i++) applyStimulus(1'b0, zbm);
    idleCycle();
    checkVal("zero_stream_dec0", {63'd0, sDec[0]}, 64'd0);

    applyStimulus(1'b0, randBm());
    for (int i = 0; i < 6; i++) idleCycle();
    applyStimulus(1'b0, randBm());
    idleCycle();

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, randBm());
    idleCycle();
    #2 rst = 1'b1;
    #1;
    checkVal("midrst_dec_valid", {63'd0, dec_valid}, 64'd0);
    checkVal("midrst_dec", dec, 64'd0);
    checkVal("midrst_best", {58'd0, best_state}, 64'd0);
    checkVal("midrst_ovf", {63'd0, pm_ovf}, 64'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, randBm());
    applyStimulus(1'b0, randBm());
    idleCycle();

    for (int i = 0; i < 5000; i++) applyStimulus((i % 700) == 0, randBm());
    idleCycle();
    idleCycle();
    $display("[TB] normalisation events in model: %0d", normCount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
